// File: rtl/bram_seq_ctrl_if.sv
// rtl/bram_seq_ctrl_if.sv - port bundle between the sequencer and the BR block-RAM wrapper
interface bram_seq_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;

  modport master (output wea, output addra, output dina, input douta);
  modport slave  (input wea, input addra, input dina, output douta);
endinterface

// File: rtl/bram_seq_ctrl.sv
// rtl/bram_seq_ctrl.sv - debounced two-button write/read sequencer driving the BR block RAM
module bram_seq_ctrl #(
  parameter int DBNC_CYC = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic [DATA_W-1:0] SW,
  input  logic              BTN_WR,
  input  logic              BTN_RD,
  bram_seq_ctrl_if.master   br,
  output logic [DATA_W-1:0] LED,
  output logic [ADDR_W:0]   CNT,
  output logic              FULL,
  output logic              EMPTY,
  output logic              BUSY
);
  localparam int CW = $clog2(DBNC_CYC + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ_REQ, READ_CAP} state_t;

  state_t            state, next_state;
  logic [1:0]        btn, sync1, sync2, db, db_d, pulse;
  logic [CW-1:0]     dcnt [2];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   rd_inc;
  logic [DATA_W-1:0] data_q;
  logic              wr_pulse, rd_pulse;

  assign btn      = {BTN_RD, BTN_WR};
  assign pulse    = db & ~db_d;
  assign wr_pulse = pulse[0];
  assign rd_pulse = pulse[1];

  // Index 0 is the write button, index 1 the read button.
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      sync1   <= '0;
      sync2   <= '0;
      db      <= '0;
      db_d    <= '0;
      dcnt[0] <= '0;
      dcnt[1] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      db_d  <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != db[i]) begin
          if (dcnt[i] == CW'(DBNC_CYC - 1)) begin
            db[i]   <= sync2[i];
            dcnt[i] <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + CW'(1);
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end

  assign FULL  = (CNT == {1'b1, {ADDR_W{1'b0}}});
  assign EMPTY = (CNT == '0);
  assign BUSY  = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (!CLR_N) state <= IDLE;
    else        state <= next_state;
  end

  // Write takes priority over a same-cycle read; pulses outside IDLE are dropped.
  always_comb begin
    next_state = state;
    br.wea     = 1'b0;
    br.addra   = rd_ptr;
    br.dina    = data_q;
    case (state)
      IDLE: begin
        if (wr_pulse && !FULL)       next_state = WRITE;
        else if (rd_pulse && !EMPTY) next_state = READ_REQ;
      end
      WRITE: begin
        br.wea     = CLR_N;
        br.addra   = wr_ptr;
        next_state = IDLE;
      end
      READ_REQ: next_state = READ_CAP;
      READ_CAP: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  assign rd_inc = {1'b0, rd_ptr} + {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      CNT    <= '0;
      LED    <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_pulse && !FULL) data_q <= SW;
        end
        WRITE: begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          CNT    <= CNT + {{ADDR_W{1'b0}}, 1'b1};
        end
        READ_CAP: begin
          // douta reflects the address registered during READ_REQ.
          LED    <= br.douta;
          rd_ptr <= (rd_inc == CNT) ? '0 : rd_inc[ADDR_W-1:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_seq_ctrl.sv
// tb/tb_bram_seq_ctrl.sv - scoreboard bench for bram_seq_ctrl with a behavioural BR model
module tb_bram_seq_ctrl;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [7:0] sw = '0;
  logic       btn_wr = 1'b0;
  logic       btn_rd = 1'b0;
  logic [7:0] led;
  logic [4:0] cnt;
  logic       full, empty, busy;

  bram_seq_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bif ();

  bram_seq_ctrl #(.DBNC_CYC(D), .ADDR_W(4), .DATA_W(8)) dut (
    .CLK(clk), .CLR_N(clr_n), .SW(sw), .BTN_WR(btn_wr), .BTN_RD(btn_rd),
    .br(bif), .LED(led), .CNT(cnt), .FULL(full), .EMPTY(empty), .BUSY(busy)
  );

  always #5 clk = ~clk;

  // Behavioural BR: one-cycle registered read.
  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (bif.wea) ram[bif.addra] <= bif.dina;
    bif.douta <= ram[bif.addra];
  end

  int checks = 0;
  int failures = 0;
  int n_wea = 0;
  int n_rd = 0;
  logic [11:0] wr_q [$];
  logic [7:0]  led_q [$];
  logic [7:0]  m_mem [16];
  int m_cnt = 0;
  int m_rd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [7:0] v);
    if (m_cnt < 16) begin
      wr_q.push_back({4'(m_cnt), v});
      m_mem[m_cnt] = v;
      m_cnt++;
    end
  endtask

  task automatic exp_rd();
    if (m_cnt > 0) begin
      led_q.push_back(m_mem[m_rd]);
      m_rd = (m_rd + 1 == m_cnt) ? 0 : m_rd + 1;
    end
  endtask

  // Monitor: each write must show wea once with the queued (addr,data);
  // each read must hold BUSY two cycles and leave LED at the queued value.
  int   run = 0;
  logic saw_wea = 1'b0;
  logic prev_busy = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!clr_n) begin
      run = 0; saw_wea = 1'b0; prev_busy = 1'b0;
    end else begin
      if (busy) begin
        run++;
        if (bif.wea) begin
          saw_wea = 1'b1;
          n_wea++;
          if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
          else begin
            logic [11:0] e;
            e = wr_q.pop_front();
            chk("write_addra", 32'(bif.addra), 32'(e[11:8]));
            chk("write_dina", 32'(bif.dina), 32'(e[7:0]));
          end
        end
      end else if (prev_busy) begin
        if (saw_wea) chk("write_busy_len", run, 1);
        else begin
          n_rd++;
          chk("read_busy_len", run, 2);
          if (led_q.size() == 0) chk("unexpected_read", 1, 0);
          else chk("read_led", 32'(led), 32'(led_q.pop_front()));
        end
        run = 0;
        saw_wea = 1'b0;
      end
      prev_busy = busy;
    end
  end

  task automatic press(input logic w, input logic r, input logic [7:0] v,
                       output int first_wea, output int busy_cyc);
    sw = v; btn_wr = w; btn_rd = r;
    first_wea = 0; busy_cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bif.wea && first_wea == 0) first_wea = k + 1;
      if (busy) busy_cyc++;
      if (k == 10) begin btn_wr = 1'b0; btn_rd = 1'b0; end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_led"}, 32'(led), 0);
    chk({tag, "_cnt"}, 32'(cnt), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_wea"}, 32'(bif.wea), 0);
    chk({tag, "_addra"}, 32'(bif.addra), 0);
    chk({tag, "_dina"}, 32'(bif.dina), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int fw, bc;
    logic found;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    clr_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Read while empty: ignored.
    exp_rd();
    press(1'b0, 1'b1, 8'h00, fw, bc);
    chk("empty_read_busy", bc, 0);
    chk("empty_read_cnt", 32'(cnt), 0);

    // Two writes; first wea lands in cycle 8 counting the rise cycle as 1.
    exp_wr(8'hA5);
    press(1'b1, 1'b0, 8'hA5, fw, bc);
    chk("first_wea_cycle", fw, 8);
    chk("write_busy_cycles", bc, 1);
    exp_wr(8'h3C);
    press(1'b1, 1'b0, 8'h3C, fw, bc);
    chk("cnt_after_2w", 32'(cnt), 2);
    chk("empty_after_2w", 32'(empty), 0);

    // Round-robin reads: A5, 3C, A5.
    for (int i = 0; i < 3; i++) begin
      exp_rd();
      press(1'b0, 1'b1, 8'h00, fw, bc);
      chk("read_no_wea", fw, 0);
      chk("read_busy_cycles", bc, 2);
    end
    chk("led_after_rr", 32'(led), 32'hA5);

    // Bounce: 2-cycle toggles never settle; only the final hold counts.
    exp_wr(8'h77);
    sw = 8'h77;
    for (int i = 0; i < 6; i++) begin
      btn_wr = (i % 2 == 0);
      repeat (2) @(posedge clk);
      #1;
    end
    press(1'b1, 1'b0, 8'h77, fw, bc);
    chk("bounce_cnt", 32'(cnt), 3);

    // Simultaneous press: write only.
    exp_wr(8'h5A);
    press(1'b1, 1'b1, 8'h5A, fw, bc);
    chk("simul_busy_cycles", bc, 1);
    chk("simul_cnt", 32'(cnt), 4);

    // Reset during the WRITE cycle aborts it.
    sw = 8'h99; btn_wr = 1'b1; found = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bif.wea) begin found = 1'b1; break; end
    end
    chk("rst_write_seen", 32'(found), 1);
    clr_n = 1'b0; btn_wr = 1'b0;
    #1;
    chk("rst_wea_suppressed", 32'(bif.wea), 0);
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    clr_n = 1'b1;
    m_cnt = 0; m_rd = 0;
    repeat (4) @(posedge clk);
    #1;

    // Fill: 17 writes, the last one blocked at FULL.
    for (int i = 0; i < 17; i++) begin
      exp_wr(8'(i));
      press(1'b1, 1'b0, 8'(i), fw, bc);
      chk("fill_wea", 32'(fw != 0), 32'(i < 16));
    end
    chk("full_cnt", 32'(cnt), 16);
    chk("full_flag", 32'(full), 1);

    // 17 reads: 0..15 then wrap to 0.
    for (int i = 0; i < 17; i++) begin
      exp_rd();
      press(1'b0, 1'b1, 8'h00, fw, bc);
    end
    chk("wrap_led", 32'(led), 0);

    repeat (4) @(posedge clk);
    #1;
    chk("wr_q_drained", wr_q.size(), 0);
    chk("led_q_drained", led_q.size(), 0);
    chk("total_wea", n_wea, 20);
    chk("total_reads", n_rd, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
